// File: rtl/bus_pkg.sv
// Shared types, mode constants and the reference add/sub rule
// for the registered add/subtract accumulator.
package bus_pkg;

   typedef enum logic {
      IDLE,
      ACC
   } state_e;

   localparam logic MODE_PAIR = 1'b0;
   localparam logic MODE_ACC  = 1'b1;

   typedef struct packed {
      logic [31:0] val;
      logic        ovf;
   } addsub_res_t;

   // w is the operand width; results live in w+1 bits
   function automatic addsub_res_t addsub_calc(
      input int unsigned w,
      input logic [31:0] base,
      input logic [31:0] opnd,
      input logic        sub,
      input logic        sat
   );
      addsub_res_t r;
      longint      t;
      longint      mx;
      mx = (longint'(1) << (w + 1)) - 1;
      if (sub) t = longint'(base) - longint'(opnd);
      else     t = longint'(base) + longint'(opnd);
      r.ovf = (t < 0) || (t > mx);
      if (r.ovf && sat) r.val = (t < 0) ? 32'd0 : mx[31:0];
      else              r.val = t[31:0] & mx[31:0];
      return r;
   endfunction

endpackage

// File: rtl/bus_addsub_acc_core.sv
// Combinational WIDTH+1 bit add/subtract with carry/borrow
// detection and optional clamp to the unsigned result range.
module addsub_core #(
   parameter int WIDTH = 4,
   parameter int SAT   = 0
) (
   input  logic [WIDTH:0]   base,
   input  logic [WIDTH-1:0] opnd,
   input  logic             sub,
   output logic [WIDTH:0]   res,
   output logic             ovf
);

   // two spare bits: base+opnd can exceed the signed WIDTH+2 range
   logic [WIDTH+2:0] t;
   logic             under;

   always_comb begin
      if (sub) t = {2'b00, base} - {3'b000, opnd};
      else     t = {2'b00, base} + {3'b000, opnd};
      under = t[WIDTH+2];
      ovf   = t[WIDTH+2] | t[WIDTH+1];
      res   = t[WIDTH:0];
      if ((SAT != 0) && ovf) res = under ? '0 : '1;
   end

endmodule

// File: rtl/bus_addsub_acc.sv
// Registered add/sub unit with accumulate bursts, sticky overflow
// and a saturating beat counter behind valid/ready handshakes.
module bus_addsub_acc
   import bus_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int SAT   = 0,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   input  logic             in_mode,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_data,
   output logic             out_ovf,
   output logic [CNT_W-1:0] out_count
);

   state_e           state_q, state_d;
   logic [WIDTH:0]   acc_q, acc_d;
   logic             ovf_acc_q, ovf_acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH:0]   out_data_q, out_data_d;
   logic             out_ovf_q, out_ovf_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;

   logic             fire;
   logic [WIDTH:0]   base;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH:0]   res;
   logic             ovf;
   logic [CNT_W-1:0] cnt_inc;

   assign in_ready  = !out_valid_q || out_ready;
   assign fire      = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ovf   = out_ovf_q;
   assign out_count = out_count_q;

   addsub_core #(
      .WIDTH(WIDTH),
      .SAT  (SAT)
   ) u_core (
      .base(base),
      .opnd(opnd),
      .sub (in_sub),
      .res (res),
      .ovf (ovf)
   );

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      ovf_acc_d   = ovf_acc_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q && !out_ready;
      out_data_d  = out_data_q;
      out_ovf_d   = out_ovf_q;
      out_count_d = out_count_q;
      cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
      base        = '0;
      opnd        = in_a;
      if (state_q == ACC) begin
         base = acc_q;
      end else if (in_mode == MODE_PAIR) begin
         base = {1'b0, in_a};
         opnd = in_b;
      end
      if (fire) begin
         unique case (state_q)
            IDLE: begin
               if (in_mode == MODE_PAIR || in_last) begin
                  out_valid_d = 1'b1;
                  out_data_d  = res;
                  out_ovf_d   = ovf;
                  out_count_d = CNT_W'(1);
               end else begin
                  acc_d     = res;
                  ovf_acc_d = ovf;
                  cnt_d     = CNT_W'(1);
                  state_d   = ACC;
               end
            end
            ACC: begin
               if (in_last) begin
                  out_valid_d = 1'b1;
                  out_data_d  = res;
                  out_ovf_d   = ovf_acc_q | ovf;
                  out_count_d = cnt_inc;
                  acc_d       = '0;
                  ovf_acc_d   = 1'b0;
                  cnt_d       = '0;
                  state_d     = IDLE;
               end else begin
                  acc_d     = res;
                  ovf_acc_d = ovf_acc_q | ovf;
                  cnt_d     = cnt_inc;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         ovf_acc_q   <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ovf_q   <= 1'b0;
         out_count_q <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         ovf_acc_q   <= ovf_acc_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ovf_q   <= out_ovf_d;
         out_count_q <= out_count_d;
      end
   end

endmodule

// File: tb/tb_bus_addsub_acc.sv
// Bench for bus_addsub_acc: three configurations (wrap, clamp,
// 2-bit counter) share one stimulus stream and one arithmetic model.
module tb_bus_addsub_acc;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] in_a;
   logic [3:0] in_b;
   logic       in_sub;
   logic       in_mode;
   logic       in_last;
   logic       out_ready;

   logic       ir0, ir1, ir2;
   logic       ov0, ov1, ov2;
   logic [4:0] od0, od1, od2;
   logic       oo0, oo1, oo2;
   logic [3:0] oc0, oc1;
   logic [1:0] oc2;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   always #5 clk = ~clk;

   bus_addsub_acc #(.WIDTH(4), .SAT(0), .CNT_W(4)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_mode(in_mode),
      .in_last(in_last), .out_valid(ov0), .out_ready(out_ready),
      .out_data(od0), .out_ovf(oo0), .out_count(oc0)
   );

   bus_addsub_acc #(.WIDTH(4), .SAT(1), .CNT_W(4)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_mode(in_mode),
      .in_last(in_last), .out_valid(ov1), .out_ready(out_ready),
      .out_data(od1), .out_ovf(oo1), .out_count(oc1)
   );

   bus_addsub_acc #(.WIDTH(4), .SAT(0), .CNT_W(2)) u2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_mode(in_mode),
      .in_last(in_last), .out_valid(ov2), .out_ready(out_ready),
      .out_data(od2), .out_ovf(oo2), .out_count(oc2)
   );

   // reference model state, one slot per configuration
   bit m_burst[3];
   int m_acc[3];
   bit m_oa[3];
   int m_cnt[3];
   bit e_valid;
   int e_data[3];
   bit e_ovf[3];
   int e_cnt[3];

   task automatic chk(input string name, input int act, input int exp);
      tot_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic model_reset();
      e_valid = 0;
      for (int k = 0; k < 3; k++) begin
         m_burst[k] = 0;
         m_acc[k]   = 0;
         m_oa[k]    = 0;
         m_cnt[k]   = 0;
         e_data[k]  = 0;
         e_ovf[k]   = 0;
         e_cnt[k]   = 0;
      end
   endtask

   task automatic model_accept(input int a, input int b, input bit sub,
                               input bit mode, input bit last);
      int  base, op, t, v, c, cmax;
      bit  o, sat;
      for (int k = 0; k < 3; k++) begin
         sat  = (k == 1);
         cmax = (k == 2) ? 3 : 15;
         base = m_burst[k] ? m_acc[k] : (mode ? 0 : a);
         op   = (m_burst[k] || mode) ? a : b;
         t    = sub ? base - op : base + op;
         o    = (t < 0) || (t > 31);
         if (!o)       v = t;
         else if (sat) v = (t < 0) ? 0 : 31;
         else          v = t & 31;
         if (!m_burst[k] && (!mode || last)) begin
            e_valid   = 1;
            e_data[k] = v;
            e_ovf[k]  = o;
            e_cnt[k]  = 1;
         end else if (!m_burst[k]) begin
            m_burst[k] = 1;
            m_acc[k]   = v;
            m_oa[k]    = o;
            m_cnt[k]   = 1;
         end else begin
            c = (m_cnt[k] + 1 > cmax) ? cmax : m_cnt[k] + 1;
            if (last) begin
               e_valid    = 1;
               e_data[k]  = v;
               e_ovf[k]   = m_oa[k] | o;
               e_cnt[k]   = c;
               m_burst[k] = 0;
            end else begin
               m_acc[k] = v;
               m_oa[k]  = m_oa[k] | o;
               m_cnt[k] = c;
            end
         end
      end
   endtask

   task automatic check_outs();
      chk("out_valid0", ov0, e_valid);
      chk("out_valid1", ov1, e_valid);
      chk("out_valid2", ov2, e_valid);
      chk("out_data0", od0, e_data[0]);
      chk("out_data1", od1, e_data[1]);
      chk("out_data2", od2, e_data[2]);
      chk("out_ovf0", oo0, e_ovf[0]);
      chk("out_ovf1", oo1, e_ovf[1]);
      chk("out_ovf2", oo2, e_ovf[2]);
      chk("out_count0", oc0, e_cnt[0]);
      chk("out_count1", oc1, e_cnt[1]);
      chk("out_count2", oc2, e_cnt[2]);
   endtask

   // called at posedge+1; returns at the next posedge+1
   task automatic cycle(input bit v, input int a, input int b,
                        input bit sub, input bit mode, input bit last,
                        input bit ordy);
      bit exp_rdy, fire;
      logic [31:0] av, bv;
      av        = a;
      bv        = b;
      in_valid  = v;
      in_a      = av[3:0];
      in_b      = bv[3:0];
      in_sub    = sub;
      in_mode   = mode;
      in_last   = last;
      out_ready = ordy;
      #1;
      exp_rdy = !e_valid || ordy;
      chk("in_ready0", ir0, exp_rdy);
      chk("in_ready1", ir1, exp_rdy);
      chk("in_ready2", ir2, exp_rdy);
      fire = v && exp_rdy;
      @(posedge clk);
      if (e_valid && ordy) e_valid = 0;
      if (fire) model_accept(a, b, sub, mode, last);
      #1;
      check_outs();
   endtask

   typedef struct {
      int a;
      int b;
      bit sub;
      int exp_wrap;
      int exp_sat;
      bit exp_ovf;
   } vec_t;

   vec_t vecs[$];

   initial begin
      vecs.push_back('{9, 8, 0, 17, 17, 0});
      vecs.push_back('{2, 5, 1, 29, 0, 1});
      vecs.push_back('{15, 15, 0, 30, 30, 0});
      vecs.push_back('{0, 0, 1, 0, 0, 0});
      vecs.push_back('{15, 0, 1, 15, 15, 0});
      vecs.push_back('{0, 15, 1, 17, 0, 1});
      vecs.push_back('{7, 3, 0, 10, 10, 0});

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_sub    = 1'b0;
      in_mode   = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outs();
      rst = 1'b0;
      @(posedge clk);
      #1;

      // pairwise table
      foreach (vecs[i]) begin
         cycle(1, vecs[i].a, vecs[i].b, vecs[i].sub, 0, 0, 1);
         chk($sformatf("vec%0d_wrap", i), od0, vecs[i].exp_wrap);
         chk($sformatf("vec%0d_sat", i), od1, vecs[i].exp_sat);
         chk($sformatf("vec%0d_ovf", i), oo0, vecs[i].exp_ovf);
         chk($sformatf("vec%0d_cnt", i), oc0, 1);
      end
      cycle(0, 0, 0, 0, 0, 0, 1);

      // accumulate 15+15+15
      cycle(1, 15, 0, 0, 1, 0, 1);
      chk("acc3_no_valid_a", ov0, 0);
      cycle(1, 15, 0, 0, 0, 0, 1);
      chk("acc3_no_valid_b", ov0, 0);
      cycle(1, 15, 0, 0, 0, 1, 1);
      chk("acc3_wrap_data", od0, 13);
      chk("acc3_wrap_ovf", oo0, 1);
      chk("acc3_sat_data", od1, 31);
      chk("acc3_count", oc0, 3);
      cycle(0, 0, 0, 0, 0, 0, 1);

      // backpressure and no-bubble refill
      cycle(1, 9, 8, 0, 0, 0, 1);
      repeat (3) begin
         cycle(1, 1, 1, 0, 0, 0, 0);
         chk("bp_hold_data", od0, 17);
      end
      in_valid  = 1'b1;
      out_ready = 1'b0;
      #1;
      chk("bp_in_ready_low", ir0, 0);
      cycle(1, 1, 1, 0, 0, 0, 1);
      chk("bp_next_valid", ov0, 1);
      chk("bp_next_data", od0, 2);
      cycle(0, 0, 0, 0, 0, 0, 1);

      // asynchronous reset mid-burst
      cycle(1, 9, 8, 0, 0, 0, 1);
      cycle(1, 5, 0, 0, 1, 0, 1);
      cycle(1, 6, 0, 0, 0, 0, 0);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("rst_valid", ov0, 0);
      chk("rst_data", od0, 0);
      chk("rst_ovf", oo0, 0);
      chk("rst_count", oc0, 0);
      model_reset();
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      cycle(1, 3, 0, 0, 1, 0, 1);
      cycle(1, 4, 0, 0, 0, 1, 1);
      chk("post_rst_data", od0, 7);
      chk("post_rst_count", oc0, 2);
      chk("post_rst_ovf", oo0, 0);
      cycle(0, 0, 0, 0, 0, 0, 1);

      // five-beat burst saturates the 2-bit counter
      cycle(1, 1, 0, 0, 1, 0, 1);
      repeat (3) cycle(1, 1, 0, 0, 0, 0, 1);
      cycle(1, 1, 0, 0, 0, 1, 1);
      chk("cnt_sat_count", oc2, 3);
      chk("cnt_sat_data", od2, 5);
      chk("cnt_sat_ovf", oo2, 0);
      chk("cnt_wide_count", oc0, 5);
      cycle(0, 0, 0, 0, 0, 0, 1);

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         cycle($urandom_range(0, 3) != 0,
               int'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)),
               $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1,
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) != 0);
      end
      repeat (2) cycle(0, 0, 0, 0, 0, 0, 1);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
